// File: rtl/seg7_capture.sv
// seg7_capture
//   Watches a multiplexed 7-segment display bus. When one digit's pattern has
//   been stable long enough, the module decodes it to a hex nibble and records
//   it per digit. Exactly one capture is made per display refresh: the pattern
//   must change before the same digit can be captured again.
//
// Parameters
//   STABLE_CYCLES  1..255      consecutive synchronized cycles a pattern must
//                              hold before it is captured
//   TIMEOUT        1..1048575  cycles without a refresh before a digit is
//                              invalidated (timeout build only)
//
// Ports
//   clk          in   1   sole clock, rising edge
//   rst          in   1   synchronous, active-high reset
//   seg          in   7   segments a..g, active-high, seg[6]=a .. seg[0]=g
//   dp           in   1   decimal point, active-high
//   line         in   4   digit enables, active-high, line[i] selects digit i
//   value        out  16  captured hex digits, digit i at value[4i+3:4i]
//   dp_out       out  4   captured decimal point per digit
//   digit_valid  out  4   digit i holds a valid decoded nibble
//   err          out  1   one-cycle pulse on a captured undecodable pattern
//   update       out  1   one-cycle pulse when value/dp_out/digit_valid change
//
// Build option
//   SEG7_CAPTURE_TIMEOUT_EN  when defined, each digit has a refresh timer that
//                            clears digit_valid[i] after TIMEOUT idle cycles.
//                            When undefined, TIMEOUT is ignored.

module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned TIMEOUT       = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic        dp,
    input  logic [3:0]  line,
    output logic [15:0] value,
    output logic [3:0]  dp_out,
    output logic [3:0]  digit_valid,
    output logic        err,
    output logic        update
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Count value at which one more matching cycle completes the stable window.
    localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

    // Decode a segment pattern. Bit 4 of the result flags a legal glyph,
    // bits 3:0 carry the nibble.
    function automatic logic [4:0] seg7_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h7E:   r = {1'b1, 4'h0};
            7'h30:   r = {1'b1, 4'h1};
            7'h6D:   r = {1'b1, 4'h2};
            7'h79:   r = {1'b1, 4'h3};
            7'h33:   r = {1'b1, 4'h4};
            7'h5B:   r = {1'b1, 4'h5};
            7'h5F:   r = {1'b1, 4'h6};
            7'h70:   r = {1'b1, 4'h7};
            7'h7F:   r = {1'b1, 4'h8};
            7'h7B:   r = {1'b1, 4'h9};
            7'h77:   r = {1'b1, 4'hA};
            7'h1F:   r = {1'b1, 4'hB};
            7'h4E:   r = {1'b1, 4'hC};
            7'h3D:   r = {1'b1, 4'hD};
            7'h4F:   r = {1'b1, 4'hE};
            7'h47:   r = {1'b1, 4'hF};
            default: r = {1'b0, 4'h0};
        endcase
        return r;
    endfunction

    function automatic logic is_onehot(input logic [3:0] l);
        return (l != 4'd0) && ((l & (l - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] l);
        logic [1:0] k;
        case (l)
            4'b0010: k = 2'd1;
            4'b0100: k = 2'd2;
            4'b1000: k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

    // Sampled bus layout: {seg[6:0], dp, line[3:0]}
    logic [11:0] bus_in;
    logic [11:0] sync1_q, sync2_q;
    logic [11:0] latch_q, latch_d;

    state_t      state_q, state_d;
    logic [7:0]  count_q, count_d;

    logic [15:0] value_q, value_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  valid_q, valid_d;
    logic        err_q, err_d;
    logic        update_q, update_d;

    logic        cap;
    logic [1:0]  cap_idx;
    logic [4:0]  cap_dec;
    logic        same_as_latch;

    assign bus_in        = {seg, dp, line};
    assign cap_idx       = onehot_index(latch_q[3:0]);
    assign cap_dec       = seg7_decode(latch_q[11:5]);
    assign same_as_latch = (sync2_q == latch_q);

`ifdef SEG7_CAPTURE_TIMEOUT_EN
    localparam logic [19:0] TMO_LOAD = 20'(TIMEOUT);
    logic [3:0][19:0] tmo_q, tmo_d;
`else
    logic [19:0] unused_timeout;
    assign unused_timeout = 20'(TIMEOUT);
`endif

    // Next-state, capture and output computation
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        latch_d  = latch_q;
        value_d  = value_q;
        dp_d     = dp_q;
        valid_d  = valid_q;
        err_d    = 1'b0;
        cap      = 1'b0;

        case (state_q)
            IDLE: begin
                if (is_onehot(sync2_q[3:0])) begin
                    latch_d = sync2_q;
                    count_d = 8'd1;
                    // A single-cycle window is already satisfied by this sample.
                    state_d = (STABLE_CYCLES <= 1) ? CAPTURE : SETTLE;
                end
            end
            SETTLE: begin
                if (!same_as_latch) begin
                    state_d = IDLE;
                end else begin
                    count_d = count_q + 8'd1;
                    if (count_q >= STABLE_LAST) begin
                        state_d = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                cap = 1'b1;
                if (cap_dec[4]) begin
                    value_d[{cap_idx, 2'b00} +: 4] = cap_dec[3:0];
                    dp_d[cap_idx]                  = latch_q[4];
                    valid_d[cap_idx]               = 1'b1;
                end else begin
                    // Unknown glyph: keep the last good nibble/dp, drop validity.
                    err_d            = 1'b1;
                    valid_d[cap_idx] = 1'b0;
                end
                state_d = HOLD;
            end
            HOLD: begin
                // Wait for the display to move on so each refresh captures once.
                if (!same_as_latch) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef SEG7_CAPTURE_TIMEOUT_EN
        tmo_d = tmo_q;
        for (int i = 0; i < 4; i++) begin
            if (cap && (cap_idx == 2'(i))) begin
                // A capture on this digit wins over a same-cycle expiry.
                tmo_d[i] = TMO_LOAD;
            end else if (tmo_q[i] != 20'd0) begin
                tmo_d[i] = tmo_q[i] - 20'd1;
                if (tmo_q[i] == 20'd1) begin
                    valid_d[i] = 1'b0;
                end
            end
        end
`endif

        update_d = (value_d != value_q) || (dp_d != dp_q) || (valid_d != valid_q);
    end

    // Register stage: synchronizer, FSM, captured digits and pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            latch_q  <= '0;
            state_q  <= IDLE;
            count_q  <= '0;
            value_q  <= '0;
            dp_q     <= '0;
            valid_q  <= '0;
            err_q    <= 1'b0;
            update_q <= 1'b0;
`ifdef SEG7_CAPTURE_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            sync1_q  <= bus_in;
            sync2_q  <= sync1_q;
            latch_q  <= latch_d;
            state_q  <= state_d;
            count_q  <= count_d;
            value_q  <= value_d;
            dp_q     <= dp_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            update_q <= update_d;
`ifdef SEG7_CAPTURE_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign value       = value_q;
    assign dp_out      = dp_q;
    assign digit_valid = valid_q;
    assign err         = err_q;
    assign update      = update_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Testbench for seg7_capture (STABLE_CYCLES=16, TIMEOUT=100).
// Each applied display pattern pushes its expected outcome to a scoreboard
// queue; after the pattern has been held, the entry is popped and compared
// against the DUT outputs and the update/err pulse counts seen meanwhile.

module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  line;
    logic [15:0] value;
    logic [3:0]  dp_out;
    logic [3:0]  digit_valid;
    logic        err;
    logic        update;

    always #5 clk = ~clk;

    seg7_capture #(
        .STABLE_CYCLES(16),
        .TIMEOUT      (100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seg        (seg),
        .dp         (dp),
        .line       (line),
        .value      (value),
        .dp_out     (dp_out),
        .digit_valid(digit_valid),
        .err        (err),
        .update     (update)
    );

    typedef struct {
        string       tag;
        logic [15:0] value;
        logic [3:0]  dpo;
        logic [3:0]  valid;
        int          upd;
        int          errs;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic [6:0]  dec_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                  7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    logic [15:0] m_value;
    logic [3:0]  m_dp;
    logic [3:0]  m_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour for one held pattern: capture into the model and
    // push the expected outputs and pulse counts.
    function automatic void model_apply(input string tag, input logic [6:0] s,
                                        input logic d, input logic [3:0] l);
        exp_t        e;
        int          k;
        int          nib;
        logic [15:0] nv;
        logic [3:0]  nd;
        logic [3:0]  nvl;
        k   = -1;
        nib = -1;
        for (int i = 0; i < 4; i++) if (l == 4'(1 << i)) k = i;
        for (int i = 0; i < 16; i++) if (dec_tab[i] == s) nib = i;
        nv     = m_value;
        nd     = m_dp;
        nvl    = m_valid;
        e.errs = 0;
        if (k >= 0) begin
            if (nib >= 0) begin
                nv[4*k +: 4] = 4'(nib);
                nd[k]        = d;
                nvl[k]       = 1'b1;
            end else begin
                e.errs = 1;
                nvl[k] = 1'b0;
            end
        end
        e.upd   = (nv != m_value || nd != m_dp || nvl != m_valid) ? 1 : 0;
        e.tag   = tag;
        e.value = nv;
        e.dpo   = nd;
        e.valid = nvl;
        m_value = nv;
        m_dp    = nd;
        m_valid = nvl;
        sb.push_back(e);
    endfunction

    // Hold current inputs for n cycles, counting pulses; first = cycle index
    // (1 = first edge after the drive) of the first update pulse, -1 if none.
    task automatic hold_cycles(input int n, output int nu, output int ne, output int first);
        nu    = 0;
        ne    = 0;
        first = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (update === 1'b1) begin
                nu++;
                if (first < 0) first = i;
            end
            if (err === 1'b1) ne++;
        end
    endtask

    task automatic gap(input int n);
        int nu, ne, first;
        @(negedge clk);
        seg  = 7'h00;
        dp   = 1'b0;
        line = 4'b0000;
        hold_cycles(n, nu, ne, first);
    endtask

    task automatic run_pattern(input string tag, input logic [6:0] s, input logic d,
                               input logic [3:0] l, input int n, output int first);
        exp_t e;
        int   nu, ne;
        model_apply(tag, s, d, l);
        @(negedge clk);
        seg  = s;
        dp   = d;
        line = l;
        hold_cycles(n, nu, ne, first);
        e = sb.pop_front();
        check({e.tag, ".value"}, 32'(value), 32'(e.value));
        check({e.tag, ".dp_out"}, 32'(dp_out), 32'(e.dpo));
        check({e.tag, ".valid"}, 32'(digit_valid), 32'(e.valid));
        check({e.tag, ".upd_cnt"}, 32'(nu), 32'(e.upd));
        check({e.tag, ".err_cnt"}, 32'(ne), 32'(e.errs));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first, nu, ne, digit, nib;
        logic d;

        m_value = '0;
        m_dp    = '0;
        m_valid = '0;
        rst  = 1'b1;
        seg  = 7'h7E;
        dp   = 1'b1;
        line = 4'b0001;
        repeat (3) @(negedge clk);
        check("rst.value", 32'(value), 32'h0);
        check("rst.dp_out", 32'(dp_out), 32'h0);
        check("rst.valid", 32'(digit_valid), 32'h0);
        check("rst.err", 32'(err), 32'h0);
        check("rst.update", 32'(update), 32'h0);
        rst  = 1'b0;
        seg  = 7'h00;
        dp   = 1'b0;
        line = 4'b0000;
        repeat (3) @(negedge clk);

        // Digit 0 shows "0": first update pulse lands 2+16+1 cycles after drive.
        run_pattern("d0_zero", 7'h7E, 1'b0, 4'b0001, 30, first);
        check("d0_zero.latency", 32'(first), 32'd19);

`ifdef SEG7_CAPTURE_TIMEOUT_EN
        // No refresh of digit 0: it must expire and pulse update once.
        gap(120);
        @(negedge clk);
        hold_cycles(1, nu, ne, first);
        check("tmo.valid0", 32'(digit_valid[0]), 32'h0);
        gap(2);
        check("tmo.value", 32'(value), 32'h0);
        // Fresh capture then expiry, counting the pulses across the window.
        run_pattern("tmo_d0", 7'h30, 1'b0, 4'b0001, 30, first);
        @(negedge clk);
        line = 4'b0000;
        hold_cycles(100, nu, ne, first);
        check("tmo.upd_cnt", 32'(nu), 32'd1);
        check("tmo.valid_after", 32'(digit_valid), 32'h0);
`else
        // Digit 2 shows "F." then the same glyph again after a blank refresh.
        gap(4);
        run_pattern("d2_F", 7'h47, 1'b1, 4'b0100, 30, first);
        gap(4);
        run_pattern("d2_F_again", 7'h47, 1'b1, 4'b0100, 30, first);

        // Digit 1: transient "3" for 10 cycles, then "5" held.
        gap(4);
        @(negedge clk);
        seg  = 7'h79;
        dp   = 1'b0;
        line = 4'b0010;
        hold_cycles(9, nu, ne, first);
        check("d1_transient.upd_cnt", 32'(nu), 32'd0);
        check("d1_transient.err_cnt", 32'(ne), 32'd0);
        run_pattern("d1_five", 7'h5B, 1'b0, 4'b0010, 30, first);

        // Blank digit 3, multi-hot enables, and a blank on a valid digit.
        gap(4);
        run_pattern("d3_blank", 7'h00, 1'b0, 4'b1000, 30, first);
        gap(4);
        run_pattern("multi_hot", 7'h7E, 1'b1, 4'b1100, 30, first);
        gap(4);
        run_pattern("d0_blank", 7'h00, 1'b1, 4'b0001, 30, first);

        // Random legal glyphs on random digits.
        for (int r = 0; r < 4; r++) begin
            digit = $urandom_range(0, 3);
            nib   = $urandom_range(0, 15);
            d     = 1'($urandom_range(0, 1));
            gap(4);
            run_pattern("rand", dec_tab[nib], d, 4'(1 << digit), 30, first);
        end

        // Reset while SETTLE count is 8: everything clears, nothing captured.
        gap(4);
        @(negedge clk);
        seg  = 7'h30;
        dp   = 1'b1;
        line = 4'b0010;
        repeat (10) @(negedge clk);
        rst  = 1'b1;
        seg  = 7'h00;
        dp   = 1'b0;
        line = 4'b0000;
        @(negedge clk);
        check("midrst.value", 32'(value), 32'h0);
        check("midrst.dp_out", 32'(dp_out), 32'h0);
        check("midrst.valid", 32'(digit_valid), 32'h0);
        check("midrst.err", 32'(err), 32'h0);
        check("midrst.update", 32'(update), 32'h0);
        rst     = 1'b0;
        m_value = '0;
        m_dp    = '0;
        m_valid = '0;
        hold_cycles(30, nu, ne, first);
        check("midrst.upd_cnt", 32'(nu), 32'd0);
        check("midrst.valid_after", 32'(digit_valid), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
